decode_issue_queue: RTL and testbench

- Instruction buffer between decode and execute in the stage4 pipeline.
- Accepts decoded instructions from decode on queue_wen and presents the oldest entry to execute.
- Honours the hazard unit's stall_queue and flush_queue controls and reports is_queue_full back to the hazard unit and decode.
- It is the queue end of the hazard-unit queue handshake.

---
 rtl/decode_issue_queue.sv | 93 +++++++++
 tb/tb_decode_issue_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: FIFO of decoded instructions between decode and execute.
// The head entry is read combinationally. A push into a full queue is dropped
// and reported by a one-cycle overflow_err pulse.
module decode_issue_queue #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             queue_wen,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    input  logic             vsetvl_in,
    input  logic             stall_queue,
    input  logic             flush_queue,
    output logic             is_queue_full,
    output logic             valid_out,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_out,
    output logic             vsetvl_out,
    output logic [PTR_W:0]   count,
    output logic             overflow_err
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        vsetvl;
    } entry_t;

    entry_t           entries [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] ptr_diff;
    logic             push;
    logic             pop;

    // Status and handshake terms; fullness depends on count only.
    assign is_queue_full = (count == CNT_W'(DEPTH));
    assign valid_out     = (count != '0);
    assign pop           = valid_out & ~stall_queue;
    assign push          = queue_wen & ~is_queue_full;
    assign ptr_diff      = wr_ptr - rd_ptr;

    // Head entry presented to execute.
    assign head       = entries[rd_ptr];
    assign instr_out  = head.instr;
    assign pc_out     = head.pc;
    assign vsetvl_out = head.vsetvl;

    // Pointer, occupancy and overflow update; flush outranks push and pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (flush_queue) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            overflow_err <= queue_wen & is_queue_full;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage write; contents are not reset.
    always_ff @(posedge CLK) begin
        if (push && !flush_queue) begin
            entries[wr_ptr] <= '{instr: instr_in, pc: pc_in, vsetvl: vsetvl_in};
        end
    end

    // Occupancy must agree with the pointer distance (equal pointers mean empty or full).
    assert property (@(posedge CLK) disable iff (RST)
        (count == {1'b0, ptr_diff}) || (is_queue_full && (ptr_diff == '0)));

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: a queue-based reference model
// compared against the DUT every cycle, plus directed literal expectations.
module tb_decode_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             CLK;
    logic             RST;
    logic             queue_wen;
    logic [31:0]      instr_in;
    logic [31:0]      pc_in;
    logic             vsetvl_in;
    logic             stall_queue;
    logic             flush_queue;
    logic             is_queue_full;
    logic             valid_out;
    logic [31:0]      instr_out;
    logic [31:0]      pc_out;
    logic             vsetvl_out;
    logic [PTR_W:0]   count;
    logic             overflow_err;

    decode_issue_queue #(.DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .queue_wen     (queue_wen),
        .instr_in      (instr_in),
        .pc_in         (pc_in),
        .vsetvl_in     (vsetvl_in),
        .stall_queue   (stall_queue),
        .flush_queue   (flush_queue),
        .is_queue_full (is_queue_full),
        .valid_out     (valid_out),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .vsetvl_out    (vsetvl_out),
        .count         (count),
        .overflow_err  (overflow_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        vs;
    } ent_t;

    ent_t mq[$];
    logic m_ovf;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour at a clock edge, from the queue rules.
    task automatic model_update();
        bit full;
        bit do_pop;
        bit do_push;
        full    = (mq.size() == DEPTH);
        do_pop  = (mq.size() != 0) && !stall_queue;
        do_push = queue_wen && !full;
        if (flush_queue) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_ovf = queue_wen && full;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{instr_in, pc_in, vsetvl_in});
        end
    endtask

    task automatic compare_model();
        chk("count", 32'(count), 32'(mq.size()));
        chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
        chk("is_queue_full", 32'(is_queue_full), 32'(mq.size() == DEPTH));
        chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
        if (mq.size() != 0) begin
            chk("instr_out", instr_out, mq[0].instr);
            chk("pc_out", pc_out, mq[0].pc);
            chk("vsetvl_out", 32'(vsetvl_out), 32'(mq[0].vs));
        end
    endtask

    // One cycle: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input logic wen, input logic [31:0] pc, input logic stall, input logic flush);
        queue_wen   = wen;
        pc_in       = pc;
        instr_in    = $urandom();
        vsetvl_in   = 1'($urandom());
        stall_queue = stall;
        flush_queue = flush;
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        compare_model();
    endtask

    task automatic do_reset();
        queue_wen   = 1'b0;
        stall_queue = 1'b1;
        flush_queue = 1'b0;
        RST = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        compare_model();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        m_ovf       = 1'b0;
        RST         = 1'b1;
        queue_wen   = 1'b0;
        instr_in    = '0;
        pc_in       = '0;
        vsetvl_in   = 1'b0;
        stall_queue = 1'b0;
        flush_queue = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_full", 32'(is_queue_full), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        RST = 1'b0;
        compare_model();

        // Three stalled pushes.
        step(1'b1, 32'h100, 1'b1, 1'b0);
        step(1'b1, 32'h104, 1'b1, 1'b0);
        step(1'b1, 32'h108, 1'b1, 1'b0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_valid", 32'(valid_out), 32'd1);
        chk("t1_pc", pc_out, 32'h100);
        chk("t1_full", 32'(is_queue_full), 32'd0);

        // Fill to DEPTH, then push once more while full.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
        chk("t2_full", 32'(is_queue_full), 32'd1);
        chk("t2_count", 32'(count), 32'd4);
        step(1'b1, 32'h110, 1'b1, 1'b0);
        chk("t2_ovf", 32'(overflow_err), 32'd1);
        chk("t2_count_hold", 32'(count), 32'd4);
        chk("t2_head", pc_out, 32'h100);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t2_ovf_clear", 32'(overflow_err), 32'd0);

        // Drain from full.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                chk("t3_pc_seq", pc_out, 32'h100 + 32'(4 * i));
                chk("t3_valid", 32'(valid_out), 32'd1);
            end
            step(1'b0, 32'h0, 1'b0, 1'b0);
        end
        chk("t3_valid_end", 32'(valid_out), 32'd0);
        chk("t3_count_end", 32'(count), 32'd0);

        // Simultaneous push and pop at count 2, wrapping the pointers.
        step(1'b1, 32'h300, 1'b1, 1'b0);
        step(1'b1, 32'h304, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h308 + 32'(4 * i), 1'b0, 1'b0);
        chk("t4_count", 32'(count), 32'd2);
        chk("t4_head", pc_out, 32'h328);

        // Flush together with push and pop.
        step(1'b1, 32'h400, 1'b1, 1'b0);
        chk("t5_count_pre", 32'(count), 32'd3);
        step(1'b1, 32'h404, 1'b0, 1'b1);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid", 32'(valid_out), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t5_not_retained", 32'(count), 32'd0);

        // Asynchronous reset in the middle of a cycle.
        step(1'b1, 32'h500, 1'b1, 1'b0);
        step(1'b1, 32'h504, 1'b1, 1'b0);
        queue_wen = 1'b0;
        #1;
        RST = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        chk("t6_async_valid", 32'(valid_out), 32'd0);
        chk("t6_async_count", 32'(count), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        compare_model();
        step(1'b1, 32'h200, 1'b1, 1'b0);
        chk("t6_head", pc_out, 32'h200);
        chk("t6_count", 32'(count), 32'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 9) < 7),
                 $urandom(),
                 1'($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
